spectrum_bank_arbiter: RTL and testbench

//  Shares one single-port synchronous spectrum RAM between the FFT result writer and the VGA display reader.
//  The RAM is split into two banks: the display reads the front bank and the writer fills the back bank.
//  The banks swap only at vertical-blank start, so a displayed frame never mixes two FFT frames.

---
 rtl/spectrum_pkg.sv | 14 +
 rtl/spectrum_swap_fsm.sv | 59 +++++
 rtl/spectrum_bank_arbiter.sv | 71 +++++++
 tb/tb_spectrum_bank_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/spectrum_pkg.sv
// Shared types and defaults for the spectrum bank arbiter.
// Swap-state encoding and width defaults live here.
package spectrum_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic {
    FILL  = 1'b0,
    READY = 1'b1
  } swapState_t;

endpackage

// File: rtl/spectrum_swap_fsm.sv
// Front/back bank swap control.
// Swaps only on vertical-blank start; counts repeated frames.
module spectrum_swap_fsm
  import spectrum_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             inClock,
  input  logic             reset,
  input  logic             vBlankStart,
  input  logic             wrFrameDone,
  output swapState_t       state,
  output logic             dispBank,
  output logic [CNT_W-1:0] repeatCount
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  swapState_t       stateNext;
  logic             bankNext;
  logic [CNT_W-1:0] cntNext;

  always_ff @(posedge inClock or posedge reset) begin
    if (reset) begin
      state       <= FILL;
      dispBank    <= 1'b0;
      repeatCount <= '0;
    end else begin
      state       <= stateNext;
      dispBank    <= bankNext;
      repeatCount <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    bankNext  = dispBank;
    cntNext   = repeatCount;
    unique case (state)
      FILL: begin
        // A frame finishing exactly at vblank swaps without a READY stop.
        if (wrFrameDone && vBlankStart) begin
          bankNext = ~dispBank;
        end else if (wrFrameDone) begin
          stateNext = READY;
        end else if (vBlankStart && repeatCount != '1) begin
          cntNext = repeatCount + ONE;
        end
      end
      READY: begin
        if (vBlankStart) begin
          bankNext  = ~dispBank;
          stateNext = FILL;
        end
      end
    endcase
  end

endmodule

// File: rtl/spectrum_bank_arbiter.sv
// Single-port spectrum RAM shared by FFT writer and VGA reader.
// Reads always win; writes fill the back bank only while filling.
module spectrum_bank_arbiter
  import spectrum_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              inClock,
  input  logic              reset,
  input  logic              vBlankStart,
  input  logic              wrReq,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  output logic              wrAck,
  input  logic              wrFrameDone,
  input  logic              rdReq,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic              rdValid,
  output logic [DATA_W-1:0] rdData,
  output logic [ADDR_W:0]   memAddr,
  output logic              memWe,
  output logic [DATA_W-1:0] memWData,
  input  logic [DATA_W-1:0] memRData,
  output logic              dispBank,
  output logic [CNT_W-1:0]  repeatCount
);

  swapState_t state;
  logic       rdPend;

  spectrum_swap_fsm #(
    .CNT_W(CNT_W)
  ) uSwap (
    .inClock    (inClock),
    .reset      (reset),
    .vBlankStart(vBlankStart),
    .wrFrameDone(wrFrameDone),
    .state      (state),
    .dispBank   (dispBank),
    .repeatCount(repeatCount)
  );

  assign wrAck  = wrReq & ~rdReq & (state == FILL);
  assign rdData = memRData;

  always_ff @(posedge inClock or posedge reset) begin
    if (reset) begin
      memAddr  <= '0;
      memWe    <= 1'b0;
      memWData <= '0;
      rdPend   <= 1'b0;
      rdValid  <= 1'b0;
    end else begin
      rdPend  <= rdReq;
      rdValid <= rdPend;
      memWe   <= wrAck;
      // Bank bit is frozen here, so an in-flight read ignores a swap.
      unique case (1'b1)
        rdReq: memAddr <= {dispBank, rdAddr};
        wrAck: begin
          memAddr  <= {~dispBank, wrAddr};
          memWData <= wrData;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spectrum_bank_arbiter.sv
// Directed self-checking bench for spectrum_bank_arbiter.
// A behavioural RAM model answers one cycle after memAddr.
module tb_spectrum_bank_arbiter;

  logic        inClock = 1'b0;
  logic        reset = 1'b1;
  logic        vBlankStart = 1'b0;
  logic        wrReq = 1'b0;
  logic [8:0]  wrAddr = '0;
  logic [15:0] wrData = '0;
  logic        wrAck;
  logic        wrFrameDone = 1'b0;
  logic        rdReq = 1'b0;
  logic [8:0]  rdAddr = '0;
  logic        rdValid;
  logic [15:0] rdData;
  logic [9:0]  memAddr;
  logic        memWe;
  logic [15:0] memWData;
  logic [15:0] memRData = '0;
  logic        dispBank;
  logic [7:0]  repeatCount;

  logic [15:0] ram [1024];

  int tests = 0;
  int failed = 0;

  spectrum_bank_arbiter dut (
    .inClock    (inClock),
    .reset      (reset),
    .vBlankStart(vBlankStart),
    .wrReq      (wrReq),
    .wrAddr     (wrAddr),
    .wrData     (wrData),
    .wrAck      (wrAck),
    .wrFrameDone(wrFrameDone),
    .rdReq      (rdReq),
    .rdAddr     (rdAddr),
    .rdValid    (rdValid),
    .rdData     (rdData),
    .memAddr    (memAddr),
    .memWe      (memWe),
    .memWData   (memWData),
    .memRData   (memRData),
    .dispBank   (dispBank),
    .repeatCount(repeatCount)
  );

  always #5 inClock = ~inClock;

  always @(posedge inClock) begin
    if (memWe) ram[memAddr] <= memWData;
    memRData <= ram[memAddr];
  end

  task automatic tick;
    @(posedge inClock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    ram[5] = 16'h1234;

    // reset state
    tick;
    tick;
    chk("rst_dispBank", 32'(dispBank), 0);
    chk("rst_memAddr", 32'(memAddr), 0);
    chk("rst_memWe", 32'(memWe), 0);
    chk("rst_memWData", 32'(memWData), 0);
    chk("rst_rdValid", 32'(rdValid), 0);
    chk("rst_repeat", 32'(repeatCount), 0);
    reset = 1'b0;
    tick;

    // 1: read latency 2
    rdReq = 1'b1;
    rdAddr = 9'd5;
    tick;
    rdReq = 1'b0;
    chk("t1_memAddr", 32'(memAddr), 32'h005);
    chk("t1_memWe", 32'(memWe), 0);
    chk("t1_rdValid_n1", 32'(rdValid), 0);
    tick;
    chk("t1_rdValid", 32'(rdValid), 1);
    chk("t1_rdData", 32'(rdData), 32'h1234);
    tick;
    chk("t1_rdValid_off", 32'(rdValid), 0);

    // 2: reads block writes
    wrReq = 1'b1;
    wrAddr = 9'd3;
    wrData = 16'hBEEF;
    rdReq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_wrAck_blocked", 32'(wrAck), 0);
      tick;
    end
    rdReq = 1'b0;
    #1;
    chk("t2_wrAck", 32'(wrAck), 1);
    tick;
    wrReq = 1'b0;
    chk("t2_memAddr", 32'(memAddr), 32'h203);
    chk("t2_memWe", 32'(memWe), 1);
    chk("t2_memWData", 32'(memWData), 32'hBEEF);
    tick;
    chk("t2_memWe_off", 32'(memWe), 0);
    chk("t2_memAddr_hold", 32'(memAddr), 32'h203);

    // 3: frame done, back-pressure, swap at vblank
    wrFrameDone = 1'b1;
    tick;
    wrFrameDone = 1'b0;
    wrReq = 1'b1;
    wrAddr = 9'd7;
    wrData = 16'h1111;
    for (int i = 0; i < 10; i++) begin
      chk("t3_wrAck_ready", 32'(wrAck), 0);
      tick;
    end
    chk("t3_memWe_ready", 32'(memWe), 0);
    vBlankStart = 1'b1;
    #1;
    chk("t3_wrAck_vbl", 32'(wrAck), 0);
    chk("t3_bank_pre", 32'(dispBank), 0);
    tick;
    vBlankStart = 1'b0;
    chk("t3_dispBank", 32'(dispBank), 1);
    chk("t3_wrAck_fill", 32'(wrAck), 1);
    tick;
    wrReq = 1'b0;
    chk("t3_memAddr", 32'(memAddr), 32'h007);
    chk("t3_memWe", 32'(memWe), 1);
    chk("t3_repeat", 32'(repeatCount), 0);
    rdReq = 1'b1;
    rdAddr = 9'd3;
    tick;
    rdReq = 1'b0;
    chk("t3_rdAddr_front", 32'(memAddr), 32'h203);
    tick;
    chk("t3_rdValid", 32'(rdValid), 1);
    chk("t3_rdData", 32'(rdData), 32'hBEEF);

    // 4: repeated frames and saturation
    for (int i = 0; i < 3; i++) begin
      vBlankStart = 1'b1;
      tick;
      vBlankStart = 1'b0;
      tick;
    end
    chk("t4_repeat3", 32'(repeatCount), 3);
    chk("t4_bank", 32'(dispBank), 1);
    for (int i = 0; i < 252; i++) begin
      vBlankStart = 1'b1;
      tick;
      vBlankStart = 1'b0;
      tick;
    end
    chk("t4_repeat255", 32'(repeatCount), 255);
    vBlankStart = 1'b1;
    tick;
    tick;
    vBlankStart = 1'b0;
    tick;
    chk("t4_saturate", 32'(repeatCount), 255);
    chk("t4_bank_hold", 32'(dispBank), 1);

    // 5: simultaneous done and vblank
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tick;
    chk("t5_rst_repeat", 32'(repeatCount), 0);
    wrFrameDone = 1'b1;
    vBlankStart = 1'b1;
    wrReq = 1'b1;
    wrAddr = 9'd9;
    wrData = 16'h2222;
    #1;
    chk("t5_wrAck_done", 32'(wrAck), 1);
    tick;
    wrFrameDone = 1'b0;
    vBlankStart = 1'b0;
    chk("t5_dispBank", 32'(dispBank), 1);
    chk("t5_repeat", 32'(repeatCount), 0);
    chk("t5_memAddr_old", 32'(memAddr), 32'h209);
    chk("t5_memWe", 32'(memWe), 1);
    chk("t5_still_fill", 32'(wrAck), 1);
    wrReq = 1'b0;
    vBlankStart = 1'b1;
    tick;
    vBlankStart = 1'b0;
    chk("t5_fill_count", 32'(repeatCount), 1);
    chk("t5_bank_hold", 32'(dispBank), 1);

    // 6: reset aborts in-flight read and write
    wrReq = 1'b1;
    wrAddr = 9'd4;
    tick;
    wrReq = 1'b0;
    rdReq = 1'b1;
    rdAddr = 9'd5;
    chk("t6_memWe_pre", 32'(memWe), 1);
    tick;
    rdReq = 1'b0;
    reset = 1'b1;
    #1;
    chk("t6_memWe", 32'(memWe), 0);
    chk("t6_dispBank", 32'(dispBank), 0);
    tick;
    chk("t6_rdValid", 32'(rdValid), 0);
    chk("t6_memAddr", 32'(memAddr), 0);
    reset = 1'b0;
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
